// File: rtl/nal_bytestream_packer.sv
// nal_bytestream_packer: Annex-B packer that buffers encoder payload bytes, adds start codes and emulation-prevention bytes
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   BYTE_IN/STROBE_IN     payload byte and its valid strobe from the encoder
//   DONE_IN               end of the current NAL payload
//   BYTE_OUT/VALID_OUT    registered Annex-B output byte, held until READY_OUT
//   READY_OUT             sink accepts the byte when VALID_OUT & READY_OUT
//   END_OUT               one-cycle pulse once a NAL has been fully emitted
//   OVERFLOW              sticky flag: an input entry was dropped on a full FIFO
//   IDLE                  FSM idle and FIFO empty
module nal_bytestream_packer #(
    parameter int FIFODEPTH = 64,
    parameter int FIFOBITS  = 6,
    parameter int LEADZERO  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] BYTE_IN,
    input  logic       STROBE_IN,
    input  logic       DONE_IN,
    output logic [7:0] BYTE_OUT,
    output logic       VALID_OUT,
    input  logic       READY_OUT,
    output logic       END_OUT,
    output logic       OVERFLOW,
    output logic       IDLE
);
    localparam logic [1:0] K_DATA = 2'd0;
    localparam logic [1:0] K_DEND = 2'd1;
    localparam logic [1:0] K_END  = 2'd2;
    localparam logic [1:0] SC_LAST = (LEADZERO != 0) ? 2'd3 : 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_SC, S_DATA, S_TAIL} state_t;

    state_t              state;
    logic [9:0]          mem [FIFODEPTH];
    logic [FIFOBITS-1:0] wr_ptr, rd_ptr;
    logic [FIFOBITS:0]   count;
    logic [1:0]          sc_cnt, zrun, z, h_kind, in_kind;
    logic [7:0]          h_byte;
    logic                empty, full, push, push_ok, pop, free, sc_done, load, epb;

    assign {h_kind, h_byte} = mem[rd_ptr];
    assign empty   = count == '0;
    assign full    = count == (FIFOBITS+1)'(FIFODEPTH);
    assign push    = STROBE_IN | DONE_IN;
    assign push_ok = push & ~full;
    assign in_kind = DONE_IN ? (STROBE_IN ? K_DEND : K_END) : K_DATA;
    // The output register is free when empty or being accepted this cycle.
    assign free    = ~VALID_OUT | READY_OUT;
    assign sc_done = state == S_SC && free && sc_cnt == SC_LAST;
    // The zero run restarts after a start code, so the first payload byte sees zero.
    assign z       = state == S_SC ? 2'd0 : zrun;
    // Payload step: runs when leaving the start code or while streaming payload,
    // so the first payload byte follows the final 01 with no bubble.
    assign load    = free && (state == S_DATA || sc_done);
    assign epb     = z == 2'd2 && h_byte <= 8'h03 && h_kind != K_END;
    // An entry leaves the FIFO when it moves into the output register (or is discarded).
    assign pop     = ~empty && ((state == S_IDLE && h_kind == K_END) || (load && ~epb));
    assign IDLE    = state == S_IDLE && empty;

    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= {in_kind, BYTE_IN};

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + FIFOBITS'(push_ok);
            rd_ptr <= rd_ptr + FIFOBITS'(pop);
            count  <= count + (FIFOBITS+1)'(push_ok) - (FIFOBITS+1)'(pop);
            if (push && full) OVERFLOW <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            sc_cnt    <= '0;
            zrun      <= '0;
            BYTE_OUT  <= '0;
            VALID_OUT <= 1'b0;
            END_OUT   <= 1'b0;
        end else begin
            END_OUT <= 1'b0;
            case (state)
                S_IDLE:
                    if (!empty && h_kind != K_END) begin
                        state     <= S_SC;
                        sc_cnt    <= '0;
                        VALID_OUT <= 1'b1;
                        BYTE_OUT  <= 8'h00;
                    end
                S_SC:
                    if (free && !sc_done) begin
                        sc_cnt   <= sc_cnt + 2'd1;
                        BYTE_OUT <= (sc_cnt + 2'd1 == SC_LAST) ? 8'h01 : 8'h00;
                    end
                S_TAIL:
                    if (free) begin
                        // A payload ending in 00 gets a trailing 03 before the NAL closes.
                        if (zrun != 2'd0) begin
                            VALID_OUT <= 1'b1;
                            BYTE_OUT  <= 8'h03;
                            zrun      <= 2'd0;
                        end else begin
                            VALID_OUT <= 1'b0;
                            END_OUT   <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                default: ;
            endcase
            if (load) begin
                if (empty) begin
                    VALID_OUT <= 1'b0;
                    state     <= S_DATA;
                end else if (h_kind == K_END) begin
                    VALID_OUT <= 1'b0;
                    state     <= S_TAIL;
                end else if (epb) begin
                    VALID_OUT <= 1'b1;
                    BYTE_OUT  <= 8'h03;
                    zrun      <= 2'd0;
                    state     <= S_DATA;
                end else begin
                    VALID_OUT <= 1'b1;
                    BYTE_OUT  <= h_byte;
                    zrun      <= h_byte != 8'h00 ? 2'd0 : (z == 2'd2 ? 2'd2 : z + 2'd1);
                    state     <= h_kind == K_DEND ? S_TAIL : S_DATA;
                end
            end
        end
    end
endmodule

// File: doc/nal_bytestream_packer.md
Name: nal_bytestream_packer

Overview:
- Sits directly downstream of the top-level encoder's byte output (tobytes_BYTE / tobytes_STROBE / tobytes_DONE).
- Turns each slice payload into an Annex-B byte stream:
  - prepends a start code prefix to every NAL;
  - inserts emulation-prevention bytes (0x03);
  - presents the result on a valid/ready byte interface for a file/UART/host sink.
- The upstream source has no backpressure, so input bytes are buffered in an internal FIFO.

Parameters:
- FIFODEPTH, 64, FIFO entries; must be a power of 2.
- FIFOBITS, 6, log2(FIFODEPTH).
- LEADZERO, 1, 1: emit 4-byte start code 00 00 00 01; 0: emit 3-byte 00 00 01.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- BYTE_IN  in  8  payload byte from tobytes.
- STROBE_IN  in  1  BYTE_IN valid this cycle.
- DONE_IN  in  1  end of current NAL payload.
- BYTE_OUT  out  8  Annex-B output byte.
- VALID_OUT  out  1  BYTE_OUT valid.
- READY_OUT  in  1  sink accepts byte when VALID_OUT & READY_OUT.
- END_OUT  out  1  1-cycle pulse when a NAL is fully emitted.
- OVERFLOW  out  1  sticky: an input entry was dropped.
- IDLE  out  1  FSM in IDLE and FIFO empty.

Behaviour:
- Reset values:
  - FIFO emptied; FSM to IDLE; zero-run counter 0.
  - BYTE_OUT=0, VALID_OUT=0, END_OUT=0, OVERFLOW=0, IDLE=1.
  - Reset mid-NAL discards all buffered and in-flight bytes; no END_OUT.
- FIFO entry = {kind[1:0], byte[7:0]}, written on the cycle's edge:
  - STROBE_IN only → kind DATA.
  - STROBE_IN & DONE_IN → kind DATA_END.
  - DONE_IN only → kind END (byte ignored).
- Push with FIFO full (registered count = FIFODEPTH) is dropped, even if a pop occurs the same cycle; OVERFLOW sets next cycle and stays set until reset.
- FSM states:
  - IDLE:
    - head DATA/DATA_END → SC, start-code counter = 0.
    - head END → popped and discarded; no output, no END_OUT (empty NAL).
  - SC: emits 00,00,00,01 (or 00,00,01 when LEADZERO=0), one byte per accepted handshake; after the final 01 → DATA, zero-run cleared.
  - DATA: examines head entry.
    - If zero-run == 2 and head byte ≤ 0x03 → EPB.
    - Else emit head byte and pop on acceptance. Zero-run becomes min(run+1,2) if byte == 0x00, else 0.
    - On acceptance of a DATA_END byte, or on popping an END entry: go to TAIL.
    - Head END is popped without output.
  - EPB: emit 0x03; on acceptance zero-run = 0 → DATA (head unchanged).
  - TAIL:
    - If last emitted payload byte was 0x00, emit 0x03 first.
    - Then pulse END_OUT for 1 cycle → IDLE, zero-run cleared.
- Handshake:
  - Output is registered.
  - Once VALID_OUT rises, BYTE_OUT holds stable until VALID_OUT & READY_OUT.
  - After acceptance, the next byte may be valid the following cycle, giving 1 byte/cycle throughput at READY_OUT=1.
- Latency: first STROBE_IN at cycle N into an empty, idle block → VALID_OUT=1 with the first start-code 00 at cycle N+2.
- Zero-run counts emitted payload bytes only. Start-code bytes and inserted 0x03 never count.
- Simultaneous push and pop on a non-full FIFO: both occur and the count is unchanged.
- Pointers wrap modulo FIFODEPTH.

Test Plan:
- Single NAL, READY_OUT=1, LEADZERO=1:
  - Stimulus: 25,B8,00,01 with DONE_IN on the 01 strobe.
  - Required: 00 00 00 01 25 B8 00 01; one END_OUT pulse after the last byte; IDLE returns to 1.
- Emulation prevention:
  - Stimulus: payload 00 00 01 00 00 00 00 03 FF, then separate DONE_IN.
  - Required: start code, then 00 00 03 01 00 00 03 00 00 03 03 FF; END_OUT.
- Trailing zero and empty NAL:
  - Stimulus: AB,00 then DONE_IN; then a lone DONE_IN.
  - Required: 00 00 00 01 AB 00 03; exactly one END_OUT; the second DONE_IN produces no output.
- Backpressure:
  - Stimulus: 40-byte burst of non-zero values; READY_OUT high 1 cycle in 3.
  - Required: order preserved; BYTE_OUT stable while VALID_OUT & !READY_OUT; OVERFLOW=0.
- Overflow:
  - Stimulus: READY_OUT=0, 65 consecutive strobes with FIFODEPTH=64.
  - Required: OVERFLOW=1 the cycle after the 65th; after READY_OUT=1, exactly the first 64 bytes emitted.
- Reset mid-NAL:
  - Stimulus: assert reset after the 3rd output byte; then a new NAL 11 22 with LEADZERO=0 build.
  - Required: all outputs at reset values; new output 00 00 01 11 22; no END_OUT for the aborted NAL.
